// File: rtl/pps_generator_mc.sv
`default_nettype none
// ============================================================================
// Module   : pps_generator_mc
// Brief    : N-channel PPS generator with pulse forming and round-robin
//            timestamp packetiser onto a byte-wide AXI-S stream.
// Revision : 1.0
// ============================================================================
module pps_generator_mc #(
    parameter int N_CH              = 2,
    parameter int RATE_DIV_WIDTH    = 28,
    parameter int PULSE_WIDTH_WIDTH = RATE_DIV_WIDTH,
    parameter int TS_WIDTH          = 32,
    parameter int TS_BYTES          = (TS_WIDTH + 7) / 8,
    parameter int DROP_WIDTH        = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [N_CH-1:0]                   i_en,
    input  logic [N_CH*RATE_DIV_WIDTH-1:0]    i_rate_div,
    input  logic [N_CH*RATE_DIV_WIDTH-1:0]    i_phase,
    input  logic [N_CH*PULSE_WIDTH_WIDTH-1:0] i_pulse_width,
    input  logic [N_CH-1:0]                   i_invert,
    input  logic                              i_resync,
    input  logic [TS_WIDTH-1:0]               i_ts,
    output logic [7:0]                        o_m_axis_ts_tdata,
    output logic                              o_m_axis_ts_tkeep,
    output logic                              o_m_axis_ts_tvalid,
    input  logic                              i_m_axis_ts_tready,
    output logic                              o_m_axis_ts_tlast,
    output logic [N_CH-1:0]                   o_pps_sample,
    output logic [N_CH-1:0]                   o_pps_formed,
    output logic [N_CH*DROP_WIDTH-1:0]        o_drop_count
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BI_W = (TS_BYTES > 1) ? $clog2(TS_BYTES) : 1;
    localparam int SH_W = TS_BYTES * 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    logic [N_CH-1:0]     sample_vec;
    logic [N_CH-1:0]     formed_vec;
    logic [N_CH-1:0]     slot_valid_vec;
    logic [N_CH-1:0]     grant_d;
    logic [TS_WIDTH-1:0] slot_ts [N_CH];

    state_t              state_q;
    logic [CH_W-1:0]     last_grant_q;
    logic [SH_W-1:0]     shift_q;
    logic [BI_W-1:0]     byte_idx_q;
    logic [7:0]          tdata_q;
    logic                tvalid_q;
    logic                tlast_q;
    logic                found_d;
    logic [CH_W-1:0]     pick_d;
    logic [SH_W-1:0]     shift_nxt_d;

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_ch
            logic                         en_q;
            logic [RATE_DIV_WIDTH-1:0]    ctr_q;
            logic                         sample_q;
            logic [PULSE_WIDTH_WIDTH-1:0] pw_ctr_q;
            logic                         formed_q;
            logic                         slot_valid_q;
            logic [TS_WIDTH-1:0]          slot_ts_q;
            logic [DROP_WIDTH-1:0]        drop_q;
            logic                         load_d;
            logic                         fire_d;

            always_comb begin
                load_d = i_en[k] & (~en_q | i_resync);
                fire_d = i_en[k] & ~load_d & (ctr_q == '0);
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    en_q         <= 1'b0;
                    ctr_q        <= '0;
                    sample_q     <= 1'b0;
                    pw_ctr_q     <= '0;
                    formed_q     <= 1'b0;
                    slot_valid_q <= 1'b0;
                    slot_ts_q    <= '0;
                    drop_q       <= '0;
                end else begin
                    en_q     <= i_en[k];
                    sample_q <= fire_d;
                    if (load_d) begin
                        ctr_q <= i_phase[k*RATE_DIV_WIDTH +: RATE_DIV_WIDTH];
                    end else if (i_en[k]) begin
                        ctr_q <= (ctr_q == '0) ? i_rate_div[k*RATE_DIV_WIDTH +: RATE_DIV_WIDTH]
                                               : ctr_q - RATE_DIV_WIDTH'(1);
                    end

                    // Former keeps running when disabled so a pulse is never cut short.
                    if (fire_d) begin
                        pw_ctr_q <= i_pulse_width[k*PULSE_WIDTH_WIDTH +: PULSE_WIDTH_WIDTH];
                        formed_q <= 1'b1;
                    end else if (pw_ctr_q != '0) begin
                        pw_ctr_q <= pw_ctr_q - PULSE_WIDTH_WIDTH'(1);
                    end else begin
                        formed_q <= 1'b0;
                    end

                    if (sample_q) begin
                        if (slot_valid_q && !grant_d[k]) begin
                            if (drop_q != {DROP_WIDTH{1'b1}}) begin
                                drop_q <= drop_q + DROP_WIDTH'(1);
                            end
                        end else begin
                            slot_valid_q <= 1'b1;
                            slot_ts_q    <= i_ts;
                        end
                    end else if (grant_d[k]) begin
                        slot_valid_q <= 1'b0;
                    end
                end
            end

            assign sample_vec[k]                           = sample_q;
            assign formed_vec[k]                           = formed_q;
            assign slot_valid_vec[k]                       = slot_valid_q;
            assign slot_ts[k]                              = slot_ts_q;
            assign o_drop_count[k*DROP_WIDTH +: DROP_WIDTH] = drop_q;
        end
    endgenerate

    function automatic logic [CH_W-1:0] rr_index(input logic [CH_W-1:0] base, input int off);
        int sum;
        sum = (int'(base) + 1 + off) % N_CH;
        return CH_W'(sum);
    endfunction

    always_comb begin
        found_d = 1'b0;
        pick_d  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!found_d && slot_valid_vec[rr_index(last_grant_q, i)]) begin
                found_d = 1'b1;
                pick_d  = rr_index(last_grant_q, i);
            end
        end
        grant_d = '0;
        if (state_q == ST_IDLE && found_d) begin
            grant_d[pick_d] = 1'b1;
        end
        shift_nxt_d = shift_q >> 8;
    end

    // last_grant resets to the top channel so channel 0 wins the first contest.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= CH_W'(N_CH - 1);
            shift_q      <= '0;
            byte_idx_q   <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (found_d) begin
                        state_q      <= ST_HDR;
                        last_grant_q <= pick_d;
                        shift_q      <= SH_W'(slot_ts[pick_d]);
                        tvalid_q     <= 1'b1;
                        tdata_q      <= 8'(pick_d);
                        tlast_q      <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (i_m_axis_ts_tready) begin
                        state_q    <= ST_DATA;
                        byte_idx_q <= '0;
                        tdata_q    <= shift_q[7:0];
                        tlast_q    <= (TS_BYTES == 1);
                    end
                end
                ST_DATA: begin
                    if (i_m_axis_ts_tready) begin
                        if (byte_idx_q == BI_W'(TS_BYTES - 1)) begin
                            state_q  <= ST_IDLE;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            tdata_q  <= '0;
                        end else begin
                            byte_idx_q <= byte_idx_q + BI_W'(1);
                            shift_q    <= shift_nxt_d;
                            tdata_q    <= shift_nxt_d[7:0];
                            tlast_q    <= ((byte_idx_q + BI_W'(1)) == BI_W'(TS_BYTES - 1));
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_m_axis_ts_tdata  = tdata_q;
    assign o_m_axis_ts_tkeep  = 1'b1;
    assign o_m_axis_ts_tvalid = tvalid_q;
    assign o_m_axis_ts_tlast  = tlast_q;
    assign o_pps_sample       = sample_vec;
    assign o_pps_formed       = formed_vec ^ i_invert;

endmodule
`default_nettype wire
